// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register file write port between ALU/link (A) and multi-cycle (B) writeback.
// Latency: 1 cycle from accept (valid & ready at a clock edge) to write_en; one write per cycle sustained.
// Backpressure: exactly one ready per cycle among valid requesters; losers hold addr/data until ready.
// Optional feature: define WB_ARB_ROUND_ROBIN_EN for round-robin contention instead of A-priority with starvation limit.
module regfile_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [ADDR_W-1:0] reg_write,
    output logic [DATA_W-1:0] write_data,
    output logic              write_en,
    output logic [3:0]        starve_cnt
);

    logic grant_a;
    logic grant_b;

`ifdef WB_ARB_ROUND_ROBIN_EN
    // last_b: 1 when the most recent transfer went to B, 0 (A) after reset
    logic last_b;

    // Grant: lone requester wins; on contention the one not granted last wins
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            grant_a = last_b;
            grant_b = !last_b;
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end

    // Track the last granted requester on every transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_b <= 1'b0;
        end else if (grant_a) begin
            last_b <= 1'b0;
        end else if (grant_b) begin
            last_b <= 1'b1;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Grant: A has priority unless B has been denied LIMIT cycles in a row
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            grant_b = (starve_cnt >= LIMIT);
            grant_a = !grant_b;
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end
`endif

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Count consecutive B denials (saturating); any non-denied cycle clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (b_valid && !grant_b) begin
            if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    // Register the winning write; writes to register 0 update addr/data but never strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write  <= '0;
            write_data <= '0;
            write_en   <= 1'b0;
        end else if (grant_a) begin
            reg_write  <= a_addr;
            write_data <= a_data;
            write_en   <= (a_addr != '0);
        end else if (grant_b) begin
            reg_write  <= b_addr;
            write_data <= b_data;
            write_en   <= (b_addr != '0);
        end else begin
            write_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: directed, table-driven self-checking bench for regfile_wb_arbiter (default build).
// Latency: checks readies before each edge and registered outputs 1 time unit after it.
// Backpressure: contention, starvation and mid-operation reset sequences are hand-written.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic [4:0]  reg_write;
    logic [31:0] write_data;
    logic        write_en;
    logic [3:0]  starve_cnt;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .reg_write  (reg_write),
        .write_data (write_data),
        .write_en   (write_en),
        .starve_cnt (starve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        exp_ar;
        logic        exp_br;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    // Apply one vector from a negedge: readies before the edge, registered outputs after it
    task automatic step(input string tag, input vec_t v);
        drive(v.av, v.aa, v.ad, v.bv, v.ba, v.bd);
        #1;
        check({tag, ".a_ready"}, 32'(a_ready), 32'(v.exp_ar));
        check({tag, ".b_ready"}, 32'(b_ready), 32'(v.exp_br));
        @(posedge clk);
        #1;
        check({tag, ".write_en"},   32'(write_en),   32'(v.exp_we));
        check({tag, ".reg_write"},  32'(reg_write),  32'(v.exp_addr));
        check({tag, ".write_data"}, write_data,      v.exp_data);
        check({tag, ".starve_cnt"}, 32'(starve_cnt), 32'(v.exp_cnt));
        @(negedge clk);
    endtask

    vec_t tbl[9];
    vec_t v;

    initial begin
        // av aa ad        bv ba bd        ar br we addr data       cnt
        tbl[0] = '{1'b1, 5'd5,  32'h1234, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd5,  32'h1234, 4'd0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 5'd5,  32'h1234, 4'd0};
        tbl[2] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd9,  32'hAAAA, 1'b0, 1'b1, 1'b1, 5'd9,  32'hAAAA, 4'd0};
        tbl[3] = '{1'b1, 5'd0,  32'hFFFF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 5'd0,  32'hFFFF, 4'd0};
        tbl[4] = '{1'b1, 5'd31, 32'h10,   1'b1, 5'd31, 32'h20,   1'b1, 1'b0, 1'b1, 5'd31, 32'h10,   4'd1};
        tbl[5] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd31, 32'h20,   1'b0, 1'b1, 1'b1, 5'd31, 32'h20,   4'd0};
        tbl[6] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  32'h55,   1'b0, 1'b1, 1'b0, 5'd0,  32'h55,   4'd0};
        tbl[7] = '{1'b1, 5'd2,  32'h22,   1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd2,  32'h22,   4'd0};
        tbl[8] = '{1'b1, 5'd3,  32'h33,   1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd3,  32'h33,   4'd0};

        // Reset held 2 clocks with A presenting a write
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.write_en",   32'(write_en),   32'd0);
        check("reset.reg_write",  32'(reg_write),  32'd0);
        check("reset.write_data", write_data,      32'd0);
        check("reset.starve_cnt", 32'(starve_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: lone requesters, register 0, same-address contention, back-to-back
        for (int i = 0; i < 9; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Starvation: A always valid, B denied 4 cycles then forced through
        for (int i = 0; i < 4; i++) begin
            v = '{1'b1, 5'(10 + i), 32'(32'h100 + i), 1'b1, 5'd7, 32'hBEEF,
                  1'b1, 1'b0, 1'b1, 5'(10 + i), 32'(32'h100 + i), 4'(i + 1)};
            step($sformatf("starve%0d", i), v);
        end
        v = '{1'b1, 5'd14, 32'h104, 1'b1, 5'd7, 32'hBEEF,
              1'b0, 1'b1, 1'b1, 5'd7, 32'hBEEF, 4'd0};
        step("starve_win", v);
        // A still waiting is served right after, with no bubble
        v = '{1'b1, 5'd14, 32'h104, 1'b0, 5'd0, 32'h0,
              1'b1, 1'b0, 1'b1, 5'd14, 32'h104, 4'd0};
        step("starve_after", v);

        // Build up a denial count, then reset on the edge that accepts B (addr 3)
        v = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33,
              1'b1, 1'b0, 1'b1, 5'd1, 32'h11, 4'd1};
        step("pre_rst", v);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h3333);
        rst_n = 1'b0;
        #1;
        check("midrst.b_ready", 32'(b_ready), 32'd1);
        @(posedge clk);
        #1;
        check("midrst.write_en",   32'(write_en),   32'd0);
        check("midrst.reg_write",  32'(reg_write),  32'd0);
        check("midrst.starve_cnt", 32'(starve_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        check("midrst.no_late_pulse", 32'(write_en), 32'd0);
        @(negedge clk);

        // B re-presents after reset and is written normally
        v = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h3333,
              1'b0, 1'b1, 1'b1, 5'd3, 32'h3333, 4'd0};
        step("re_present", v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
